// File: rtl/seg7_pkg.sv
// Shared constants and types for the six-digit multiplexed seven-segment driver.
package seg7_pkg;

  localparam int DIGITS = 6;

  typedef logic [0:0] state_t;
  localparam state_t ST_BLANK = 1'b0;
  localparam state_t ST_DRIVE = 1'b1;

  typedef logic [2:0] idx_t;
  localparam idx_t IDX_SECL = 3'd0;
  localparam idx_t IDX_SECM = 3'd1;
  localparam idx_t IDX_MINL = 3'd2;
  localparam idx_t IDX_MINM = 3'd3;
  localparam idx_t IDX_HRL  = 3'd4;
  localparam idx_t IDX_HRM  = 3'd5;

  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [5:0] AN_OFF   = 6'h3F;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low {g,f,e,d,c,b,a} decoder; non-decimal codes show a dash.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0: seg = 7'b1000000;
      4'd1: seg = 7'b1111001;
      4'd2: seg = 7'b0100100;
      4'd3: seg = 7'b0110000;
      4'd4: seg = 7'b0011001;
      4'd5: seg = 7'b0010010;
      4'd6: seg = 7'b0000010;
      4'd7: seg = 7'b1111000;
      4'd8: seg = 7'b0000000;
      4'd9: seg = 7'b0010000;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan.sv
// Six-digit time-multiplexed display scanner with per-frame input snapshot and inter-digit blanking.
// Define SEG_LZB_EN to blank the hours-tens digit when it is zero.
//
// state    | meaning
// ST_BLANK | all anodes off for BLANK_CYCLES clocks at slot start
// ST_DRIVE | one anode on, segments show the snapshot digit of idx_q
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] hrm,
  input  logic [3:0] hrl,
  input  logic [3:0] minm,
  input  logic [3:0] minl,
  input  logic [3:0] secm,
  input  logic [3:0] secl,
  output logic [6:0] seg,
  output logic [5:0] an,
  output logic       dp
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(SCAN_DIV - BLANK_CYCLES - 1);

  state_t                  state_q, state_d;
  idx_t                    idx_q, idx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DIGITS-1:0][3:0]  snap_q, snap_d;
  logic [6:0]              seg_q, seg_d;
  logic [5:0]              an_q, an_d;
  logic                    dp_q, dp_d;

  logic [DIGITS-1:0][3:0]  live;
  logic [3:0]              digit_sel;
  logic [6:0]              digit_seg;

  assign live = {hrm, hrl, minm, minl, secm, secl};

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q + CNT_W'(1);
    snap_d  = snap_q;
    case (state_q)
      ST_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = ST_DRIVE;
          cnt_d   = '0;
          if (idx_q == IDX_SECL) snap_d = live;
        end
      end
      default: begin
        if (cnt_q == DRIVE_LAST) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          idx_d   = (idx_q == IDX_HRM) ? IDX_SECL : idx_q + 3'd1;
        end
      end
    endcase
  end

  // Mux from the next-state snapshot so slot 0 shows the digits captured on the same edge.
  always_comb begin
    digit_sel = 4'd0;
    case (idx_d)
      IDX_SECL: digit_sel = snap_d[IDX_SECL];
      IDX_SECM: digit_sel = snap_d[IDX_SECM];
      IDX_MINL: digit_sel = snap_d[IDX_MINL];
      IDX_MINM: digit_sel = snap_d[IDX_MINM];
      IDX_HRL:  digit_sel = snap_d[IDX_HRL];
      IDX_HRM:  digit_sel = snap_d[IDX_HRM];
      default:  digit_sel = 4'd0;
    endcase
  end

  bcd_to_seg7 u_dec (
    .bcd (digit_sel),
    .seg (digit_seg)
  );

  always_comb begin
    an_d  = an_q;
    seg_d = seg_q;
    dp_d  = dp_q;
    if (state_d != state_q) begin
      if (state_d == ST_DRIVE) begin
        an_d  = ~(6'b000001 << idx_d);
        seg_d = digit_seg;
        dp_d  = !(((idx_d == IDX_HRL) || (idx_d == IDX_MINL)) && !snap_d[IDX_SECL][0]);
`ifdef SEG_LZB_EN
        if ((idx_d == IDX_HRM) && (digit_sel == 4'd0)) begin
          an_d  = AN_OFF;
          seg_d = SEG_OFF;
        end
`endif
      end else begin
        an_d  = AN_OFF;
        seg_d = SEG_OFF;
        dp_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_BLANK;
      idx_q   <= IDX_SECL;
      cnt_q   <= '0;
      snap_q  <= '0;
      an_q    <= AN_OFF;
      seg_q   <= SEG_OFF;
      dp_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      snap_q  <= snap_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Scoreboard bench for seg7_scan: stimulus pushes per-cycle expected outputs, a monitor pops and compares.
module tb_seg7_scan;

  localparam int SCAN_DIV     = 8;
  localparam int BLANK_CYCLES = 2;
  localparam int FRAME        = 6 * SCAN_DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] hrm = '0, hrl = '0, minm = '0, minl = '0, secm = '0, secl = '0;
  logic [3:0] n_hrm = '0, n_hrl = '0, n_minm = '0, n_minl = '0, n_secm = '0, n_secl = '0;
  logic [6:0] seg;
  logic [5:0] an;
  logic       dp;

  always #5 clk = ~clk;

  seg7_scan #(.SCAN_DIV(SCAN_DIV), .BLANK_CYCLES(BLANK_CYCLES)) dut (
    .clk  (clk),
    .rst  (rst),
    .hrm  (hrm),
    .hrl  (hrl),
    .minm (minm),
    .minl (minl),
    .secm (secm),
    .secl (secl),
    .seg  (seg),
    .an   (an),
    .dp   (dp)
  );

  typedef struct {
    logic [13:0] v;
    int          pos;
  } exp_t;

  exp_t       exp_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         m_pos = 0;
  logic [3:0] m_snap [6] = '{default: 4'd0};

  function automatic logic [6:0] ref_dec(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  // Expected {an, seg, dp} for a given position within the frame.
  function automatic logic [13:0] model_out(input int pos);
    int         slot;
    int         ph;
    logic [5:0] a;
    logic [6:0] s;
    logic       p;
    slot = pos / SCAN_DIV;
    ph   = pos % SCAN_DIV;
    a = 6'h3F;
    s = 7'h7F;
    p = 1'b1;
    if (ph >= BLANK_CYCLES) begin
      a = ~(6'b000001 << slot);
      s = ref_dec(m_snap[slot]);
      if ((slot == 2 || slot == 4) && !m_snap[0][0]) p = 1'b0;
`ifdef SEG_LZB_EN
      if (slot == 5 && m_snap[5] == 4'd0) begin
        a = 6'h3F;
        s = 7'h7F;
      end
`endif
    end
    return {a, s, p};
  endfunction

  task automatic check(input string name, input logic [13:0] act, input logic [13:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
               name, act[13:8], act[7:1], act[0], want[13:8], want[7:1], want[0]);
    end
  endtask

  task automatic set_time(input logic [3:0] a, b, c, d, e, f);
    n_hrm = a; n_hrl = b; n_minm = c; n_minl = d; n_secm = e; n_secl = f;
  endtask

  // One cycle: at the falling edge apply inputs/reset and queue what the next rising edge must produce.
  task automatic step(input logic r);
    @(negedge clk);
    rst = r;
    hrm = n_hrm; hrl = n_hrl; minm = n_minm; minl = n_minl; secm = n_secm; secl = n_secl;
    if (!r) begin
      m_pos = 0;
    end else begin
      m_pos = (m_pos + 1) % FRAME;
      if (m_pos == BLANK_CYCLES) m_snap = '{secl, secm, minl, minm, hrl, hrm};
    end
    exp_q.push_back('{v: model_out(m_pos), pos: m_pos});
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check($sformatf("slot%0d_ph%0d", e.pos / SCAN_DIV, e.pos % SCAN_DIV), {an, seg, dp}, e.v);
      end
    end
  end

  initial begin
    set_time(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
    repeat (3) step(1'b0);
    check("reset_hold", {an, seg, dp}, {6'h3F, 7'h7F, 1'b1});

    // 12:34:56, then 23:59:59 applied in slot 3 of the second frame
    set_time(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
    repeat (FRAME) step(1'b1);
    repeat (3 * SCAN_DIV) step(1'b1);
    set_time(4'd2, 4'd3, 4'd5, 4'd9, 4'd5, 4'd9);
    repeat (3 * SCAN_DIV) step(1'b1);
    repeat (FRAME) step(1'b1);

    // invalid hours-units code, odd seconds
    set_time(4'd1, 4'hA, 4'd0, 4'd0, 4'd0, 4'd5);
    repeat (FRAME) step(1'b1);

    // even seconds, hours-tens zero
    set_time(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd4);
    repeat (FRAME) step(1'b1);

    // asynchronous reset while slot 2 is driving
    repeat (2 * SCAN_DIV + 4) step(1'b1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst", {an, seg, dp}, {6'h3F, 7'h7F, 1'b1});
    repeat (3) step(1'b0);
    set_time(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
    repeat (FRAME) step(1'b1);

    @(posedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
